mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares the core's single synchronous memory port between instruction fetch and the execute stage's load/store path.
- Serialises accesses through a registered FSM. Data accesses take priority; a starvation counter guarantees fetch forward progress.
- Sits between the fetch and execute stages on one side and the unified memory on the other, and supplies each requester a stall signal.

## Interface

Parameters:

- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- STARVE_MAX, 4, consecutive data grants while fetch waits before fetch is forced; legal range 1..15

Ports (clock and reset: reset rst, asynchronous, active-high; clock clk):

- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data, meaningful when if_valid
- if_valid  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_valid (combinational)
- d_req  in  1  data request, level, held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, meaningful when d_valid
- d_valid  out  1  one-cycle completion pulse for load or store
- d_stall  out  1  d_req & ~d_valid (combinational)
- mem_en  out  1  one-cycle access strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en
- busy  out  1  state != IDLE

## Operation

FSM states: IDLE, ISSUE, WAIT, DONE.

- **IDLE:** when any request is high, latch the grant, address, we and wdata, then go to ISSUE. With no request, stay in IDLE.
- **ISSUE:** mem_en=1 and mem_we=latched we, with the latched addr/wdata, for exactly one cycle. Load the latency counter with MEM_LAT, then go to WAIT.
- **WAIT:** decrement the counter each cycle. In the last WAIT cycle (counter == 1), capture mem_rdata into the granted requester's rdata register, then go to DONE.
- **DONE:** assert the granted requester's valid for one cycle, then return to IDLE.
- The mem_* outputs are registered. mem_addr, mem_wdata and mem_we hold their last values outside ISSUE; mem_en is 0 outside ISSUE.
- Stores still run through WAIT. d_valid pulses on completion and d_rdata is updated with the (ignored) mem_rdata.
- rdata registers hold their value until the next completion for the same requester.

Arbitration, evaluated in IDLE only:

- Only one request high: that requester wins.
- Both high and starve_cnt < STARVE_MAX: data wins, and starve_cnt increments (saturating).
- Both high and starve_cnt == STARVE_MAX: fetch wins.
- Any fetch grant clears starve_cnt to 0.
- A data grant while if_req is low leaves starve_cnt unchanged.

Boundary conditions:

- A request that drops before its valid pulse (protocol violation) does not abort the access; the access completes and the valid pulse is still issued.
- In DONE, the requester may keep or re-raise req. IDLE in the following cycle samples whatever is present.
- Reset at any point: return to IDLE. All outputs, rdata registers, starve_cnt and the latency counter go to 0. An in-flight access is abandoned; a store already strobed may have written.

## Timing

- Reset values: if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- The stall outputs follow their requests combinationally.
- Request sampled high in IDLE at cycle t:
  - mem_en in cycle t+1
  - mem_rdata captured at the end of cycle t+1+MEM_LAT
  - valid pulse in cycle t+2+MEM_LAT
- Latency is 3 cycles at MEM_LAT=1.
- Minimum spacing between accesses is 3+MEM_LAT cycles, because IDLE is always visited.
- busy is high from cycle t+1 through the DONE cycle.

## Structure

- Package mem_arb_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, DONE
  - grant encoding: GNT_IF=1'b0, GNT_D=1'b1
  - latency counter width: 4 bits
- One sub-module, arb_starve_counter: a 4-bit saturating counter with clear and increment inputs, compared against STARVE_MAX.
- The FSM and datapath registers stay in mem_port_arbiter.

## Test plan

- **Single load:** MEM_LAT=1, d_req=1, d_we=0, d_addr=0x40, memory returns 0xDEADBEEF → mem_en at t+1 with mem_addr=0x40, d_valid pulse at t+3, d_rdata=0xDEADBEEF, d_stall low only in that cycle.
- **Single store:** d_we=1, d_addr=0x10, d_wdata=0x1234 → one mem_en cycle with mem_we=1, mem_wdata=0x1234; d_valid at t+3; if_valid stays 0.
- **Simultaneous requests:** if_req and d_req held high continuously with STARVE_MAX=4 → grant order D,D,D,D,IF,D,D,D,D,IF; starve_cnt clears after each IF grant.
- **Latency parameter:** MEM_LAT=3, fetch from 0x100 → if_valid at t+5 with the data present on mem_rdata in cycle t+4; back-to-back fetches spaced 6 cycles apart.
- **Reset mid-access:** assert rst during WAIT of a load → all outputs 0 immediately; after release with d_req still high, a new access starts and completes normally with fresh data.
- **Fetch only:** if_req held with d_req=0 → repeated fetch grants, starve_cnt stays 0, busy high except for one IDLE cycle between accesses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts data grants won while fetch was also waiting; saturates at STARVE_MAX.
module arb_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic atMax
);

  logic [3:0] cnt;

  assign atMax = (cnt == 4'(STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && !atMax) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store traffic onto one synchronous memory port.
// Data has priority; fetch is forced after STARVE_MAX consecutive data wins.
//
// state | meaning
// IDLE  | arbitrate; latch winner's address/we/wdata into the mem_* registers
// ISSUE | mem_en high for one cycle; load latency counter
// WAIT  | count down memory latency; capture mem_rdata when counter hits 1
// DONE  | winner's valid pulse is high; return to IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arbState_t state, nextState;
  logic grant;
  logic [LAT_CNT_W-1:0] latCnt;
  logic anyReq, ifWins, idleGrant, lastWait, starveAtMax;

  assign anyReq    = if_req | d_req;
  assign ifWins    = if_req & (~d_req | starveAtMax);
  assign idleGrant = (state == IDLE) & anyReq;
  assign lastWait  = (latCnt == LAT_CNT_W'(1));

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;
  assign busy     = (state != IDLE);

  // Only a contested data win counts toward starvation.
  arb_starve_counter #(.STARVE_MAX(STARVE_MAX)) uStarve (
    .clk   (clk),
    .rst   (rst),
    .clr   (idleGrant & ifWins),
    .inc   (idleGrant & ~ifWins & if_req),
    .atMax (starveAtMax)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (lastWait) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= GNT_IF;
      latCnt    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            grant    <= ifWins ? GNT_IF : GNT_D;
            mem_en   <= 1'b1;
            mem_we   <= ~ifWins & d_we;
            mem_addr <= ifWins ? if_addr : d_addr;
            if (!ifWins) mem_wdata <= d_wdata;
          end
        end
        ISSUE: latCnt <= LAT_CNT_W'(MEM_LAT);
        WAIT: begin
          latCnt <= latCnt - LAT_CNT_W'(1);
          if (lastWait) begin
            if (grant == GNT_D) begin
              d_rdata <= mem_rdata;
              d_valid <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-accurate memory model and scoreboard.
module tb_mem_port_arbiter;

  localparam int TB_LAT = 3;
  localparam int TB_STARVE = 4;
  localparam logic [31:0] GARB = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = GARB;
  logic if_valid, if_stall, d_valid, d_stall, mem_en, mem_we, busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(TB_LAT), .STARVE_MAX(TB_STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memData(input logic [31:0] a, input int seq);
    return 32'hDEADBEEF ^ (a ^ 32'h40) ^ (32'(seq) << 16);
  endfunction

  // Memory: read data is present only in the cycle exactly TB_LAT after mem_en.
  int memSeq = 0;
  int remain = 0;
  logic [31:0] pend = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      pend = memData(mem_addr, memSeq);
      memSeq++;
      remain = TB_LAT;
    end
    if (remain > 0) begin
      remain--;
      mem_rdata <= (remain == 0) ? pend : GARB;
    end else begin
      mem_rdata <= GARB;
    end
  end

  typedef struct {
    logic gntD;
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t expQ[$];
  int accNum = 0;
  bit inFlight = 1'b0;
  int issueCyc = 0;

  task automatic pushExp(input logic gntD, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata);
    exp_t e;
    e.gntD = gntD; e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = memData(addr, accNum);
    rdata = e.rdata;
    accNum++;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      inFlight = 1'b0;
    end else begin
      if (mem_en) begin
        compared++;
        assert (!inFlight && expQ.size() != 0) else begin
          mismatched++;
          $error("FAIL issue_expected: observed unexpected mem_en at cycle %0d, expected none", cyc);
        end
        if (expQ.size() != 0) begin
          e = expQ[0];
          check("issue_addr", mem_addr, e.addr);
          check("issue_we", 32'(mem_we), 32'(e.we));
          if (e.we) check("issue_wdata", mem_wdata, e.wdata);
        end
        inFlight = 1'b1;
        issueCyc = cyc;
      end
      if (if_valid || d_valid) begin
        compared++;
        assert (expQ.size() != 0) else begin
          mismatched++;
          $error("FAIL valid_expected: observed valid pulse at cycle %0d, expected none", cyc);
        end
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          check("valid_port", 32'({if_valid, d_valid}), e.gntD ? 32'd1 : 32'd2);
          check("valid_rdata", e.gntD ? d_rdata : if_rdata, e.rdata);
          check("valid_latency", 32'(cyc), 32'(issueCyc + TB_LAT + 1));
        end
        inFlight = 1'b0;
      end
    end
  end

  // sel: 0 = fetch, 1 = data, 2 = either
  task automatic waitValid(input int sel, input int budget, input string tag, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0 && if_valid) || (sel == 1 && d_valid) || (sel == 2 && (if_valid || d_valid))) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: observed no valid within %0d cycles, expected a pulse", tag, budget);
    end
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_d_valid"}, 32'(d_valid), 32'd0);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t, at, prev;
    logic [31:0] ex;
    logic [31:0] ef[3];
    logic orderD[10];
    orderD = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    #2;
    checkZero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single load
    t = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    pushExp(1'b1, 1'b0, 32'h40, 32'h0, ex);
    #1;
    check("load_d_stall_req", 32'(d_stall), 32'd1);
    check("load_if_stall", 32'(if_stall), 32'd0);
    @(negedge clk);
    check("load_mem_en", 32'(mem_en), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    waitValid(1, 20, "load_wait", at);
    check("load_valid_cycle", 32'(at), 32'(t + 2 + TB_LAT));
    check("load_rdata", d_rdata, 32'hDEADBEEF);
    check("load_d_stall_done", 32'(d_stall), 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    check("load_valid_single", 32'(d_valid), 32'd0);
    check("load_idle_busy", 32'(busy), 32'd0);
    check("load_rdata_hold", d_rdata, ex);

    // Single store
    t = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1234;
    pushExp(1'b1, 1'b1, 32'h10, 32'h1234, ex);
    waitValid(1, 20, "store_wait", at);
    check("store_valid_cycle", 32'(at), 32'(t + 2 + TB_LAT));
    check("store_rdata", d_rdata, ex);
    check("store_if_rdata", if_rdata, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);

    // Fetch only, back to back
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 3; k++) pushExp(1'b0, 1'b0, 32'h100, 32'h0, ef[k]);
    prev = -1;
    for (int k = 0; k < 3; k++) begin
      waitValid(0, 20, "fetch_wait", at);
      if (prev >= 0) check("fetch_spacing", 32'(at - prev), 32'(TB_LAT + 3));
      prev = at;
      check("fetch_rdata", if_rdata, ef[k]);
      check("fetch_stall_done", 32'(if_stall), 32'd0);
      if (k < 2) begin
        @(negedge clk);
        check("fetch_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("fetch_issue_busy", 32'(busy), 32'd1);
      end
    end
    if_req = 1'b0;
    @(negedge clk);

    // Both requesting continuously
    if_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 10; k++) pushExp(orderD[k], 1'b0, orderD[k] ? 32'h300 : 32'h200, 32'h0, ex);
    for (int k = 0; k < 10; k++) begin
      waitValid(2, 20, "both_wait", at);
      check("both_grant_order", 32'(d_valid), 32'(orderD[k]));
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Request dropped before completion
    t = cyc;
    d_req = 1'b1; d_addr = 32'h80;
    pushExp(1'b1, 1'b0, 32'h80, 32'h0, ex);
    @(negedge clk);
    d_req = 1'b0;
    waitValid(1, 20, "drop_wait", at);
    check("drop_valid_cycle", 32'(at), 32'(t + 2 + TB_LAT));
    check("drop_rdata", d_rdata, ex);
    @(negedge clk);

    // Reset during WAIT
    d_req = 1'b1; d_addr = 32'h44;
    pushExp(1'b1, 1'b0, 32'h44, 32'h0, ex);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkZero("midreset");
    check("midreset_d_stall", 32'(d_stall), 32'd1);
    expQ.delete(0);
    @(negedge clk);
    rst = 1'b0;
    t = cyc;
    pushExp(1'b1, 1'b0, 32'h44, 32'h0, ex);
    waitValid(1, 20, "postreset_wait", at);
    check("postreset_valid_cycle", 32'(at), 32'(t + 2 + TB_LAT));
    check("postreset_rdata", d_rdata, ex);
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
